// File: rtl/hub75_capture_if.sv
// CPU data-bus port of hub75_capture: address, write data and byte mask, strobes,
// plus the registered read data / ack and the combinational address-hit flag.
interface hub75_capture_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ready;
    logic        active;

    modport master (output addr, wdata, wmask, wen, ren, input rdata, ready, active);
    modport slave  (input addr, wdata, wmask, wen, ren, output rdata, ready, active);
endinterface

// File: rtl/hub75_capture.sv
// HUB75 stream sniffer: counts ON shifts per sub-pixel over PWM_STEPS screens into
// two banks (top/bottom half) and exposes the reconstructed frame on the CPU bus.
module hub75_capture #(
    parameter int          ROWS        = 64,
    parameter int          COLS        = 64,
    parameter int          PWM_STEPS   = 128,
    parameter int          SYNC_ROWSEL = ROWS / 2 - 1,
    parameter logic [31:0] BASEADDR    = 32'h8200_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    hub75_capture_if.slave            bus,
    input  logic                      R0,
    input  logic                      G0,
    input  logic                      B0,
    input  logic                      R1,
    input  logic                      G1,
    input  logic                      B1,
    input  logic [$clog2(ROWS/2)-1:0] ROWSEL,
    input  logic                      CLK_HUB75,
    input  logic                      LATCH
);
    localparam int ROWS_2  = ROWS / 2;
    localparam int RS_W    = $clog2(ROWS_2);
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int HALF    = ROWS_2 * COLS;
    localparam int BANK_AW = $clog2(HALF);
    localparam int WORDS   = ROWS * COLS;
    localparam int WORD_W  = $clog2(WORDS + 1);
    localparam int PIN_W   = RS_W + 8;

    localparam logic [COL_W-1:0]  COLS_C      = COL_W'(COLS);
    localparam logic [RS_W-1:0]   LAST_ROW    = RS_W'(ROWS_2 - 1);
    localparam logic [RS_W-1:0]   SYNC_C      = RS_W'(SYNC_ROWSEL);
    localparam logic [7:0]        LAST_SCREEN = 8'(PWM_STEPS - 1);
    localparam logic [WORD_W-1:0] CTRL_WORD   = WORD_W'(WORDS);
    localparam logic [WORD_W-1:0] HALF_WORD   = WORD_W'(HALF);
    localparam logic [31:0]       SPAN        = 32'((WORDS + 1) * 4);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state;
    logic [RS_W-1:0]    row;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_after;
    logic [7:0]         screen;
    logic               done;
    logic               overrun;
    logic               short_row;

    // ---------------- input synchronisers and edge detect ----------------
    logic [PIN_W-1:0] pins;
    logic [PIN_W-1:0] sync1;
    logic [PIN_W-1:0] sync2;
    logic [1:0]       edge_prev;
    logic             px_edge;
    logic             lt_edge;
    logic [RS_W-1:0]  rowsel_s;

    assign pins = {ROWSEL, LATCH, CLK_HUB75, B1, G1, R1, B0, G0, R0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            edge_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync1 -> sync2 a real two-stage shift.
            sync1     <= pins;
            sync2     <= sync1;
            edge_prev <= sync2[7:6];
        end
    end

    assign px_edge  = sync2[6] & ~edge_prev[0];
    assign lt_edge  = sync2[7] & ~edge_prev[1];
    assign rowsel_s = sync2[PIN_W-1:8];

    // ---------------- bus decode ----------------
    logic [31:0]        offset;
    logic [WORD_W-1:0]  word;
    logic               is_ctrl;
    logic               is_top;
    logic [BANK_AW-1:0] bus_bank_addr;
    logic               ctrl_wr;
    logic               unused_bits;

    assign offset        = bus.addr - BASEADDR;
    assign bus.active    = (bus.addr >= BASEADDR) && (offset < SPAN);
    assign word          = offset[WORD_W+1:2];
    assign is_ctrl       = (word == CTRL_WORD);
    assign is_top        = (word < HALF_WORD);
    assign bus_bank_addr = is_top ? BANK_AW'(word) : BANK_AW'(word - HALF_WORD);
    assign ctrl_wr       = bus.active & bus.wen & is_ctrl & bus.wmask[0];
    assign unused_bits   = ^{bus.wdata[31:2], bus.wmask[3:1]};

    // ---------------- capture pipeline ----------------
    logic [23:0]        bank_top [HALF];
    logic [23:0]        bank_bot [HALF];
    logic [BANK_AW-1:0] pix_addr;
    logic [BANK_AW-1:0] rd_addr;
    logic               issue;
    logic               p1_valid;
    logic               p1_first;
    logic [5:0]         p1_bits;
    logic [BANK_AW-1:0] p1_addr;
    logic [23:0]        rd_top;
    logic [23:0]        rd_bot;
    logic               wr_valid;
    logic [BANK_AW-1:0] wr_addr;
    logic [23:0]        wr_top;
    logic [23:0]        wr_bot;
    logic [23:0]        buf_word;

    assign pix_addr  = BANK_AW'(row) * BANK_AW'(COLS) + BANK_AW'(col);
    assign rd_addr   = (state == CAPTURE) ? pix_addr : bus_bank_addr;
    assign issue     = (state == CAPTURE) && px_edge && (col < COLS_C);
    assign col_after = issue ? col + 1'b1 : col;

    function automatic logic [7:0] acc(input logic [7:0] old, input logic b, input logic first);
        if (first)
            return {7'd0, b};
        if (b && old != 8'hFF)
            return old + 8'd1;
        return old;
    endfunction

    function automatic logic [23:0] acc3(input logic [23:0] old, input logic [2:0] b,
                                         input logic first);
        return {acc(old[23:16], b[2], first), acc(old[15:8], b[1], first),
                acc(old[7:0], b[0], first)};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_valid <= 1'b0;
            wr_valid <= 1'b0;
        end else begin
            p1_valid <= issue;
            wr_valid <= p1_valid;
        end
    end

    // NOTE: the banks and pipeline data carry no reset so they map onto plain RAM;
    // only the valid bits above gate whether anything is written.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            bank_top[wr_addr] <= wr_top;
            bank_bot[wr_addr] <= wr_bot;
        end
        rd_top   <= bank_top[rd_addr];
        rd_bot   <= bank_bot[rd_addr];
        p1_addr  <= pix_addr;
        p1_bits  <= sync2[5:0];
        p1_first <= (screen == 8'd0);
        wr_addr  <= p1_addr;
        wr_top   <= acc3(rd_top, p1_bits[2:0], p1_first);
        wr_bot   <= acc3(rd_bot, p1_bits[5:3], p1_first);
    end

    // A read right after DONE can race the last pending write; forward it.
    always_comb begin
        buf_word = is_top ? bank_top[rd_addr] : bank_bot[rd_addr];
        if (wr_valid && wr_addr == rd_addr)
            buf_word = is_top ? wr_top : wr_bot;
    end

    // ---------------- bus response ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ready <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= bus.active & (bus.ren | bus.wen);
            bus.rdata <= '0;
            if (bus.active && bus.ren) begin
                if (is_ctrl)
                    bus.rdata <= {27'd0, short_row, overrun, done, state};
                else if (state != CAPTURE)
                    bus.rdata <= {8'h00, buf_word};
            end
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            screen    <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            short_row <= 1'b0;
        end else if (ctrl_wr && bus.wdata[1]) begin
            state <= IDLE;
            done  <= 1'b0;
        end else if (ctrl_wr && bus.wdata[0]) begin
            state <= WAIT_SYNC;
            done  <= 1'b0;
        end else begin
            case (state)
                WAIT_SYNC: begin
                    if (lt_edge && rowsel_s == SYNC_C) begin
                        state     <= CAPTURE;
                        row       <= '0;
                        col       <= '0;
                        screen    <= '0;
                        overrun   <= 1'b0;
                        short_row <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (px_edge) begin
                        if (col < COLS_C)
                            col <= col + 1'b1;
                        else
                            overrun <= 1'b1;
                    end
                    // Latch is applied after any same-cycle pixel, hence col_after.
                    if (lt_edge) begin
                        if (col_after < COLS_C)
                            short_row <= 1'b1;
                        col <= '0;
                        if (row == LAST_ROW) begin
                            row    <= '0;
                            screen <= screen + 8'd1;
                            if (screen == LAST_SCREEN) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_capture.sv
// Randomised bench for hub75_capture: drives HUB75 frames and bus accesses and
// compares against a per-pixel intensity model held in plain integer arrays.
module tb_hub75_capture;
    localparam int          ROWS  = 8;
    localparam int          COLS  = 6;
    localparam int          PWM   = 4;
    localparam int          R2    = ROWS / 2;
    localparam int          WORDS = ROWS * COLS;
    localparam logic [31:0] BASE  = 32'h8200_0000;
    localparam logic [31:0] CTRL  = BASE + 32'(WORDS * 4);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       R0 = 1'b0, G0 = 1'b0, B0 = 1'b0, R1 = 1'b0, G1 = 1'b0, B1 = 1'b0;
    logic [1:0] ROWSEL = 2'd0;
    logic       CLK_HUB75 = 1'b0;
    logic       LATCH = 1'b0;

    hub75_capture_if bus ();

    hub75_capture #(
        .ROWS(ROWS), .COLS(COLS), .PWM_STEPS(PWM), .SYNC_ROWSEL(R2 - 1), .BASEADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .ROWSEL(ROWSEL), .CLK_HUB75(CLK_HUB75), .LATCH(LATCH)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mdl [ROWS][COLS][3];   // expected intensity per pixel row, column, channel (R,G,B)

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] model_word(input int i);
        int r = i / COLS;
        int c = i % COLS;
        return {8'h00, 8'(mdl[r][c][2]), 8'(mdl[r][c][1]), 8'(mdl[r][c][0])};
    endfunction

    // One shift of row pair r: first screen overwrites, later screens count up to 255.
    task automatic model_px(input int r, input int c, input logic [5:0] bits, input bit first);
        for (int h = 0; h < 2; h++)
            for (int ch = 0; ch < 3; ch++) begin
                int pr = r + h * R2;
                int b  = int'(bits[h * 3 + ch]);
                if (first)
                    mdl[pr][c][ch] = b;
                else if (mdl[pr][c][ch] + b <= 255)
                    mdl[pr][c][ch] = mdl[pr][c][ch] + b;
            end
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic rdy);
        @(negedge clk);
        bus.addr = a;
        bus.ren  = 1'b1;
        @(negedge clk);
        rdy     = bus.ready;
        d       = bus.rdata;
        bus.ren = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                             output logic rdy);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.wmask = m;
        bus.wen   = 1'b1;
        @(negedge clk);
        rdy     = bus.ready;
        bus.wen = 1'b0;
    endtask

    task automatic shift_px(input logic [5:0] bits);
        {B1, G1, R1, B0, G0, R0} = bits;
        tick(3);
        CLK_HUB75 = 1'b1;
        tick(3);
        CLK_HUB75 = 1'b0;
        tick(1);
    endtask

    task automatic send_latch(input logic [1:0] rs);
        ROWSEL = rs;
        tick(3);
        LATCH = 1'b1;
        tick(3);
        LATCH = 1'b0;
        tick(3);
    endtask

    // Sync latch, then PWM screens of R2 rows; screen 0 rows 0/1 use the given edge counts.
    task automatic run_frame(input int n_row0, input int n_row1);
        logic [5:0] bits;
        int         n;
        send_latch(2'(R2 - 1));
        for (int s = 0; s < PWM; s++)
            for (int r = 0; r < R2; r++) begin
                n = (s == 0 && r == 0) ? n_row0 : (s == 0 && r == 1) ? n_row1 : COLS;
                for (int c = 0; c < n; c++) begin
                    bits = (c < COLS) ? 6'($urandom) : 6'h3f;
                    shift_px(bits);
                    if (c < COLS)
                        model_px(r, c, bits, s == 0);
                end
                send_latch(2'(r));
            end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        logic        rdy;
        bit          seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            bus_read(CTRL, d, rdy);
            if (d[1:0] == 2'd3)
                seen = 1'b1;
        end
        check({tag, " reached DONE"}, 32'(seen), 32'd1);
    endtask

    task automatic check_buffer(input string tag);
        logic [31:0] d;
        logic        rdy;
        for (int i = 0; i < WORDS; i++) begin
            bus_read(BASE + 32'(i * 4), d, rdy);
            check($sformatf("%s[%0d]", tag, i), d, model_word(i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        rdy;
        logic [5:0]  bits;

        bus.addr  = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        bus.wen   = 1'b0;
        bus.ren   = 1'b0;

        tick(3);
        check("reset ready", 32'(bus.ready), 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        tick(2);

        bus_read(CTRL, d, rdy);
        check("reset status", d, 32'd0);
        check("ctrl read ready", 32'(rdy), 32'd1);

        // ready latency: low in the request cycle, high the next, low again after
        @(negedge clk);
        bus.addr = CTRL;
        bus.ren  = 1'b1;
        check("active at CTRL", 32'(bus.active), 32'd1);
        check("ready in request cycle", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("ready one cycle later", 32'(bus.ready), 32'd1);
        bus.ren = 1'b0;
        @(negedge clk);
        check("ready single pulse", 32'(bus.ready), 32'd0);

        bus.addr = CTRL + 32'd4;
        #1 check("active past CTRL", 32'(bus.active), 32'd0);
        bus.addr = BASE - 32'd4;
        #1 check("active below base", 32'(bus.active), 32'd0);
        bus_read(CTRL + 32'd4, d, rdy);
        check("no ready out of range", 32'(rdy), 32'd0);

        // sync: wrong ROWSEL keeps waiting, SYNC_ROWSEL starts capture
        bus_write(CTRL, 32'd1, 4'h1, rdy);
        bus_read(CTRL, d, rdy);
        check("armed state", d, 32'd1);
        send_latch(2'd1);
        bus_read(CTRL, d, rdy);
        check("no sync on rowsel 1", d, 32'd1);
        send_latch(2'(R2 - 1));
        bus_read(CTRL, d, rdy);
        check("sync to capture", d, 32'd2);
        bus_read(BASE, d, rdy);
        check("buffer zero in capture", d, 32'd0);
        bus_write(CTRL, 32'd2, 4'h1, rdy);
        bus_read(CTRL, d, rdy);
        check("abort to idle", d, 32'd0);

        // full random frame
        bus_write(CTRL, 32'd1, 4'h1, rdy);
        run_frame(COLS, COLS);
        wait_done("frame1");
        bus_read(CTRL, d, rdy);
        check("frame1 status", d, 32'd7);
        check_buffer("frame1 word");

        // buffer writes are acknowledged but ignored
        bus_write(BASE + 32'd20, 32'hDEAD_BEEF, 4'hF, rdy);
        check("buffer write ready", 32'(rdy), 32'd1);
        bus_read(BASE + 32'd20, d, rdy);
        check("buffer write ignored", d, model_word(5));

        // overrun on row 0, short row 1, both in screen 0
        bus_write(CTRL, 32'd1, 4'h1, rdy);
        run_frame(COLS + 1, 2);
        wait_done("frame2");
        bus_read(CTRL, d, rdy);
        check("frame2 status", d, 32'd31);
        check_buffer("frame2 word");

        // abort mid-capture; ARM|ABORT together must abort
        bus_write(CTRL, 32'd1, 4'h1, rdy);
        send_latch(2'(R2 - 1));
        for (int c = 0; c < 3; c++) begin
            bits = 6'($urandom);
            shift_px(bits);
            model_px(0, c, bits, 1'b1);
        end
        tick(6);
        bus_write(CTRL, 32'd3, 4'h1, rdy);
        bus_read(CTRL, d, rdy);
        check("abort status", d, 32'd0);
        check_buffer("abort word");

        // reset asserted with an RMW and a bus read in flight
        bus_write(CTRL, 32'd1, 4'h1, rdy);
        send_latch(2'(R2 - 1));
        {B1, G1, R1, B0, G0, R0} = 6'h3f;
        tick(3);
        CLK_HUB75 = 1'b1;
        tick(2);
        bus.addr = CTRL;
        bus.ren  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("ready cleared by reset", 32'(bus.ready), 32'd0);
        check("rdata cleared by reset", bus.rdata, 32'd0);
        bus.ren   = 1'b0;
        CLK_HUB75 = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        bus_read(CTRL, d, rdy);
        check("status after reset", d, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
